// File: rtl/booth_pkg.sv
// Shared types and width helpers for the sequential Booth multiplier.
// Build option: define BOOTH_SIGNED_EN for two's-complement operands and product.
package booth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

`ifdef BOOTH_SIGNED_EN
    localparam int IW_EXTRA = 0;
`else
    // Unsigned operands get a zero guard bit so 2^W-1 stays positive inside Booth.
    localparam int IW_EXTRA = 1;
`endif

    function automatic int calc_iw(input int width);
        return width + IW_EXTRA;
    endfunction

    function automatic int calc_cnt_w(input int width);
        return $clog2(calc_iw(width) + 1);
    endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: add/subtract/hold on A, then arithmetic shift of {A,Q,q_m1}.
module booth_step #(
    parameter int IW = 9
) (
    input  logic [IW-1:0] a_in,
    input  logic [IW-1:0] q_in,
    input  logic          q_m1_in,
    input  logic [IW-1:0] m_in,
    output logic [IW-1:0] a_out,
    output logic [IW-1:0] q_out,
    output logic          q_m1_out
);

    logic [IW-1:0] sum;

    // Wrapping add/sub is intentional; the Booth recoding keeps the result exact.
    always_comb begin
        sum = a_in;
        case ({q_in[0], q_m1_in})
            2'b01:   sum = a_in + m_in;
            2'b10:   sum = a_in - m_in;
            default: sum = a_in;
        endcase
    end

    assign a_out[IW-1] = sum[IW-1];
    assign q_out[IW-1] = sum[0];
    assign q_m1_out    = q_in[0];

    for (genvar gi = 0; gi < IW - 1; gi++) begin : g_shift
        assign a_out[gi] = sum[gi+1];
        assign q_out[gi] = q_in[gi+1];
    end

endmodule

// File: rtl/seq_booth_multplr.sv
// Sequential radix-2 Booth multiplier with start/done handshake and registered product.
// Build option: BOOTH_SIGNED_EN selects signed operands (default build is unsigned).
module seq_booth_multplr
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int IW    = calc_iw(WIDTH);
    localparam int CNT_W = calc_cnt_w(WIDTH);

    state_t               state_reg, state_next;
    logic [IW-1:0]        m_reg, m_next;
    logic [IW-1:0]        a_reg, a_next;
    logic [IW-1:0]        q_reg, q_next;
    logic                 q_m1_reg, q_m1_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [2*WIDTH-1:0]   product_reg, product_next;

    logic [IW-1:0]        m_ext, b_ext;
    logic [IW-1:0]        a_step, q_step;
    logic                 q_m1_step;
    logic [2*IW-1:0]      aq_step;

`ifdef BOOTH_SIGNED_EN
    assign m_ext = a;
    assign b_ext = b;
`else
    assign m_ext = {1'b0, a};
    assign b_ext = {1'b0, b};
    // Guard-bit half of the wide result never reaches the product.
    logic unused_hi;
    assign unused_hi = ^aq_step[2*IW-1:2*WIDTH];
`endif

    booth_step #(.IW(IW)) u_step (
        .a_in     (a_reg),
        .q_in     (q_reg),
        .q_m1_in  (q_m1_reg),
        .m_in     (m_reg),
        .a_out    (a_step),
        .q_out    (q_step),
        .q_m1_out (q_m1_step)
    );

    assign aq_step = {a_step, q_step};

    always_comb begin
        state_next   = state_reg;
        m_next       = m_reg;
        a_next       = a_reg;
        q_next       = q_reg;
        q_m1_next    = q_m1_reg;
        cnt_next     = cnt_reg;
        product_next = product_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    m_next     = m_ext;
                    q_next     = b_ext;
                    a_next     = '0;
                    q_m1_next  = 1'b0;
                    cnt_next   = CNT_W'(IW);
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                a_next    = a_step;
                q_next    = q_step;
                q_m1_next = q_m1_step;
                cnt_next  = cnt_reg - 1'b1;
                // Last iteration: the stepped value is the final product.
                if (cnt_reg == CNT_W'(1)) begin
                    product_next = aq_step[2*WIDTH-1:0];
                    state_next   = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg   <= ST_IDLE;
            m_reg       <= '0;
            a_reg       <= '0;
            q_reg       <= '0;
            q_m1_reg    <= 1'b0;
            cnt_reg     <= '0;
            product_reg <= '0;
        end else begin
            state_reg   <= state_next;
            m_reg       <= m_next;
            a_reg       <= a_next;
            q_reg       <= q_next;
            q_m1_reg    <= q_m1_next;
            cnt_reg     <= cnt_next;
            product_reg <= product_next;
        end
    end

    assign busy    = (state_reg == ST_RUN);
    assign done    = (state_reg == ST_DONE);
    assign product = product_reg;

endmodule

// File: tb/tb_seq_booth_multplr.sv
// Self-checking bench: directed vectors on an 8-bit instance plus random back-to-back
// traffic on 4/8/16-bit instances against a plain multiply reference.
module tb_seq_booth_multplr;

`ifdef BOOTH_SIGNED_EN
    localparam int IW_EXTRA = 0;
`else
    localparam int IW_EXTRA = 1;
`endif
    localparam int IW8 = 8 + IW_EXTRA;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr, start;
    logic [7:0]  a, b;
    logic        busy, done;
    logic [15:0] product;

    int total = 0;
    int bad   = 0;

    seq_booth_multplr #(.WIDTH(8)) u_dut (
        .clk     (clk),
        .clr     (clr),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one op from IDLE, measure edges from the accepting edge to done.
    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib,
                          input logic [15:0] exp, input string name);
        int lat;
        @(negedge clk);
        a = ia; b = ib; start = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start = 1'b0;
        check({name, "_busy_run"}, busy, 1);
        while (!done && lat < IW8 + 6) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({name, "_latency"}, lat, IW8 + 1);
        check({name, "_busy_at_done"}, busy, 0);
        check({name, "_product"}, product, exp);
        @(posedge clk);
        @(negedge clk);
        check({name, "_done_pulse"}, done, 0);
        check({name, "_product_hold"}, product, exp);
        $display("op %s a=%02h b=%02h product=%04h lat=%0d", name, ia, ib, product, lat);
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    vec_t vecs[6];

    // Random traffic per width; each instance runs its own back-to-back stream.
    for (genvar gi = 0; gi < 3; gi++) begin : g_rnd
        localparam int W   = (gi == 0) ? 4 : (gi == 1) ? 8 : 16;
        localparam int IWR = W + IW_EXTRA;

        logic             r_clr, r_start, r_busy, r_done;
        logic [W-1:0]     r_a, r_b;
        logic [2*W-1:0]   r_product;
        bit               fin_flag = 1'b0;

        seq_booth_multplr #(.WIDTH(W)) u_dut (
            .clk     (clk),
            .clr     (r_clr),
            .start   (r_start),
            .a       (r_a),
            .b       (r_b),
            .busy    (r_busy),
            .done    (r_done),
            .product (r_product)
        );

        function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
            longint p;
`ifdef BOOTH_SIGNED_EN
            p = longint'($signed(x)) * longint'($signed(y));
`else
            p = longint'(x) * longint'(y);
`endif
            return (2*W)'(p);
        endfunction

        function automatic logic [W-1:0] pick(input int sel);
            logic [W-1:0] v;
            v = W'($urandom);
            if (sel == 0) v = '1;
            if (sel == 1) begin
                v = '0;
                v[W-1] = 1'b1;
            end
            if (sel == 2) v = '0;
            return v;
        endfunction

        initial begin
            r_clr = 1'b1; r_start = 1'b0; r_a = '0; r_b = '0;
            repeat (3) @(posedge clk);
            @(negedge clk);
            r_clr = 1'b0;
            for (int n = 0; n < 1000; n++) begin
                logic [W-1:0]   x, y;
                logic [2*W-1:0] e;
                int             lat;
                x = pick($urandom_range(0, 7));
                y = pick($urandom_range(0, 7));
                e = ref_mul(x, y);
                r_a = x; r_b = y; r_start = 1'b1;
                @(posedge clk);
                lat = 1;
                @(negedge clk);
                r_start = 1'($urandom_range(0, 1));
                r_a = W'($urandom);
                while (!r_done && lat < IWR + 6) begin
                    @(posedge clk);
                    lat++;
                    @(negedge clk);
                    r_start = 1'($urandom_range(0, 1));
                    r_b = W'($urandom);
                end
                check($sformatf("rnd_w%0d_latency", W), lat, IWR + 1);
                check($sformatf("rnd_w%0d_product", W), r_product, e);
                @(posedge clk);
                @(negedge clk);
                check($sformatf("rnd_w%0d_done_pulse", W), r_done, 0);
                $display("rnd w=%0d n=%0d a=%0h b=%0h product=%0h exp=%0h lat=%0d",
                         W, n, x, y, r_product, e, lat);
            end
            r_start = 1'b0;
            fin_flag = 1'b1;
        end
    end

    initial begin
        int wait_cnt;
`ifdef BOOTH_SIGNED_EN
        vecs[0] = '{8'hF9, 8'h03, 16'hFFEB};
        vecs[1] = '{8'h80, 8'h80, 16'h4000};
        vecs[2] = '{8'h7F, 8'h80, 16'hC080};
        vecs[3] = '{8'h00, 8'hA5, 16'h0000};
        vecs[4] = '{8'hFF, 8'hFF, 16'h0001};
        vecs[5] = '{8'h7F, 8'h7F, 16'h3F01};
`else
        vecs[0] = '{8'hF9, 8'h03, 16'h02EB};
        vecs[1] = '{8'h80, 8'h80, 16'h4000};
        vecs[2] = '{8'h7F, 8'h80, 16'h3F80};
        vecs[3] = '{8'h00, 8'hA5, 16'h0000};
        vecs[4] = '{8'hFF, 8'hFF, 16'hFE01};
        vecs[5] = '{8'h7F, 8'h7F, 16'h3F01};
`endif
        clr = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_product", product, 0);
        clr = 1'b0;

        for (int i = 0; i < 6; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));

        // start pulsed mid-RUN with new operands must be ignored
        @(negedge clk);
        a = vecs[0].a; b = vecs[0].b; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        a = 8'h55; b = 8'h66; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_cnt = 0;
        while (!done && wait_cnt < IW8 + 6) begin
            @(posedge clk);
            wait_cnt++;
            @(negedge clk);
        end
        check("ignore_start_done_seen", done, 1);
        check("ignore_start_busy_at_done", busy, 0);
        check("ignore_start_product", product, vecs[0].p);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("ignore_start_no_queue", busy, 0);
        $display("op ignore_start product=%04h", product);

        // clr mid-RUN discards the op and clears the product
        a = 8'h7F; b = 8'h03; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrun_clr_busy", busy, 0);
        check("midrun_clr_done", done, 0);
        check("midrun_clr_product", product, 0);
        $display("op midrun_clr busy=%0b done=%0b product=%04h", busy, done, product);
        clr = 1'b0;
        run_op(vecs[1].a, vecs[1].b, vecs[1].p, "after_clr");

        wait_cnt = 0;
        while (!(g_rnd[0].fin_flag && g_rnd[1].fin_flag && g_rnd[2].fin_flag)
               && wait_cnt < 60000) begin
            @(posedge clk);
            wait_cnt++;
        end
        check("random_streams_finished",
              g_rnd[0].fin_flag && g_rnd[1].fin_flag && g_rnd[2].fin_flag, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
